// File: rtl/seq_det_pkg.sv
// Shared defaults and the pattern-length validity check for the programmable sequence detector.
package seq_det_pkg;

  localparam int unsigned SEQ_DET_MAX_LEN     = 8;
  localparam logic [31:0] SEQ_DET_RST_PATTERN = 32'b01101;
  localparam int unsigned SEQ_DET_RST_LEN     = 5;

  function automatic logic len_ok(input int unsigned len,
                                  input int unsigned max_len = SEQ_DET_MAX_LEN);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus a fill counter saturating at MAX_LEN; one-cycle update, no backpressure.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_DET_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic               clr_i,
  output logic [MAX_LEN-1:0] hist_o,
  output logic [LEN_W-1:0]   fill_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // clr together with shift keeps the shifted history but restarts the fill count
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_i};
      if (fill_q != LEN_W'(MAX_LEN)) fill_d = fill_q + 1'b1;
    end else if (clr_i) begin
      hist_d = '0;
    end
    if (clr_i) fill_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector, Moore flag one cycle after the final pattern bit; no backpressure.
// Define SEQ_DET_COUNT_EN to build the saturating detection counter; otherwise det_cnt is tied to 0.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = SEQ_DET_MAX_LEN,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(SEQ_DET_RST_PATTERN),
  parameter int unsigned        RST_LEN     = SEQ_DET_RST_LEN,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               valid,
  input  logic               overlap,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               seq_det,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   det_cnt
);

  logic               accept, cfg_ok, match, hist_clr;
  logic [MAX_LEN-1:0] hist, hist_post, mask;
  logic [LEN_W-1:0]   fill, fill_post;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               det_q, det_d, err_q, err_d;

  assign accept   = valid & ~cfg_we;
  assign cfg_ok   = cfg_we & len_ok(32'(cfg_len), MAX_LEN);
  assign hist_clr = cfg_ok | (match & ~overlap);

  seq_det_hist #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
    .clk_i  (clk),
    .rst_ni (rst),
    .shift_i(accept),
    .bit_i  (din),
    .clr_i  (hist_clr),
    .hist_o (hist),
    .fill_o (fill)
  );

  // Match is judged on the history as it will look after this bit is shifted in
  assign hist_post = {hist[MAX_LEN-2:0], din};
  assign fill_post = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end

  assign match = accept & (fill_post >= len_q) & (((hist_post ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    det_d = det_q;
    err_d = cfg_we & ~cfg_ok;
    if (cfg_ok) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      det_d = 1'b0;
    end else if (accept) begin
      det_d = match;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q <= RST_PATTERN;
      len_q <= LEN_W'(RST_LEN);
      det_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      det_q <= det_d;
      err_q <= err_d;
    end
  end

  assign seq_det = det_q;
  assign cfg_err = err_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                     cnt_d = '0;
    else if (match && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign det_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign det_cnt        = '0;
`endif

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable, parametrised serial sequence detector; generation after the fixed 5-bit Moore detector. Samples one bit per `valid` cycle and compares the most recent `cfg_len` bits against a runtime-loadable pattern of up to `MAX_LEN` bits. Detection runs in overlap or non-overlap mode, and a saturating detection counter is optional. It sits on the same serial input path as the fixed detector and is a drop-in replacement for it.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, at least 2.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field.
- `RST_PATTERN`, `'b01101`: pattern after reset, right-aligned.
- `RST_LEN`, 5: pattern length after reset, 1..MAX_LEN.
- `CNT_W`, 16: detection counter width.

Ports:
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `din`  in  1: serial data bit.
- `valid`  in  1: `din` is accepted only on cycles where this is 1.
- `overlap`  in  1: 1 = overlapping detection, 0 = non-overlapping; sampled on each accepted bit.
- `cfg_we`  in  1: load `cfg_pattern` and `cfg_len`.
- `cfg_pattern`  in  MAX_LEN: new pattern. Bit `[cfg_len-1]` is the first bit received, bit `[0]` is the last.
- `cfg_len`  in  LEN_W: new pattern length.
- `cnt_clr`  in  1: clear the detection counter.
- `seq_det`  out  1: Moore detect flag.
- `cfg_err`  out  1: one-cycle pulse when a configuration write is rejected.
- `det_cnt`  out  CNT_W: number of detections, saturating.

## Operation
- State registers:
  - `hist[MAX_LEN-1:0]`: history shift register.
  - `fill`: number of bits accepted since the last clear, saturating at MAX_LEN.
  - `pat`, `len`: the active pattern and length.
  - `seq_det`, `det_cnt`.
- On an accepted bit (`valid=1`, `cfg_we=0`):
  - `hist <= {hist[MAX_LEN-2:0], din}`.
  - `fill` increments, saturating at MAX_LEN.
  - A match occurs when the post-shift `fill >= len` and the low `len` bits of the post-shift `hist` equal the low `len` bits of `pat`.
  - On a match, `seq_det <= 1`; otherwise `seq_det <= 0`.
  - On a match with `overlap=0`, `fill <= 0`, so no bit is reused. With `overlap=1`, `fill` keeps counting.
- `valid=0`: all state holds. `seq_det` keeps its value (Moore behaviour: the flag reflects the last accepted bit).
- `cfg_we=1` with `1 <= cfg_len <= MAX_LEN`:
  - Loads `pat` and `len`.
  - Clears `fill`, `hist` and `seq_det`.
  - Any `din` on the same cycle is dropped.
- `cfg_we=1` with `cfg_len=0` or `cfg_len > MAX_LEN`:
  - `pat`, `len`, `fill`, `hist` and `seq_det` are unchanged.
  - `din` on that cycle is still dropped.
  - `cfg_err=1` for one cycle.
- Detection counter:
  - Increments on every match and saturates at all-ones.
  - `cnt_clr` has priority over an increment on the same cycle; the counter reads 0 the following cycle.
- Reset (`rst=0` at a clock edge, including in the middle of a sequence):
  - Outputs: `seq_det=0`, `cfg_err=0`, `det_cnt=0`.
  - State: `hist=0`, `fill=0`, `pat=RST_PATTERN`, `len=RST_LEN`.
  - A partial sequence in progress is discarded.

## Timing
- Detection latency is one cycle: `seq_det` rises on the cycle after the edge at which the final pattern bit is accepted.
- `seq_det` falls only at the next accepted bit that does not match, at a configuration write, or at reset.
- Back-to-back matches hold `seq_det` high continuously; the matches are counted through `det_cnt`.
- `det_cnt` updates on the same edge as `seq_det`.
- `cfg_err` goes high the cycle after the rejected write and lasts one cycle.
- A new configuration takes effect for the first bit accepted after the `cfg_we` cycle.
- No combinational path exists from inputs to outputs.

## Configuration
- `SEQ_DET_COUNT_EN` defined: the detection counter and `cnt_clr` are implemented as described above.
- `SEQ_DET_COUNT_EN` undefined: no counter logic is built. `det_cnt` is tied to 0 and `cnt_clr` is ignored. The port list is unchanged.

## Structure
- Package `seq_det_pkg` holds:
  - default constants: `SEQ_DET_MAX_LEN`, `SEQ_DET_RST_PATTERN`, `SEQ_DET_RST_LEN`;
  - the length-valid check function, `len_ok(len)`.
- One sub-module, `seq_det_hist`:
  - contents: the history shift register and the saturating `fill` counter;
  - inputs: `shift`, `bit`, `clr`;
  - outputs: `hist` and `fill`.
- The top level holds the compare and mask logic, the mode control, the configuration registers and the counter.

## Test plan
1. Reset defaults, `overlap=1`, stream `01101101` with all bits valid → `seq_det` high after bit 5 and after bit 8; `det_cnt=2`.
2. Same stream with `overlap=0` → `seq_det` high only after bit 5; `det_cnt=1`.
3. `01101` with `valid=0` gaps of 3 cycles between bits, including gaps after the final bit → `seq_det` rises after the fifth accepted bit and holds through every following `valid=0` cycle.
4. Load `cfg_pattern='b111`, `cfg_len=3`, `overlap=1`, then stream `1111` → matches on bits 3 and 4, `seq_det` high across both, `det_cnt=2`. Then write `cfg_len=0` → `cfg_err` pulses once; stream `111` → still detects.
5. Send `0110` of the default pattern, pull `rst` low for 1 cycle, then send `1` → no detect. Then send a full `01101` → detect.
6. `CNT_W=2`, 5 detections → `det_cnt` saturates at 3. Assert `cnt_clr` on the same cycle as a match → `det_cnt=0`. Repeat without `SEQ_DET_COUNT_EN` → `det_cnt` stays 0 throughout.
